// File: rtl/hwag_cfg_pkg.sv
// Shared types and constants for the hwag configuration sequencer.
package hwag_cfg_pkg;

  localparam int CFG_AW = 8;
  localparam int CFG_DW = 16;

  // hwag register map entries referenced by the default config table
  localparam logic [CFG_AW-1:0] HWATHNB     = 8'd4;
  localparam logic [CFG_AW-1:0] HWACR0      = 8'd63;
  localparam logic [CFG_AW-1:0] HWATHVL     = 8'd70;
  localparam logic [CFG_AW-1:0] HWAIGNCHRGL = 8'd127;

  typedef enum logic [2:0] {
    L_FETCH, L_WRITE, L_READ, L_WAIT, IDLE, H_WRITE, H_READ, H_WAIT
  } state_t;

  typedef struct packed {
    logic              verify;
    logic [CFG_AW-1:0] addr;
    logic [CFG_DW-1:0] data;
  } tbl_entry_t;

  function automatic tbl_entry_t mk_entry(input logic v,
                                          input logic [CFG_AW-1:0] a,
                                          input logic [CFG_DW-1:0] d);
    tbl_entry_t e;
    e.verify = v;
    e.addr   = a;
    e.data   = d;
    return e;
  endfunction

endpackage

// File: rtl/hwag_cfg_rom.sv
// Synchronous configuration table ROM, one-cycle read latency.
module hwag_cfg_rom
  import hwag_cfg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int EW    = 1 + CFG_AW + CFG_DW,
  parameter logic [EW-1:0] INIT [DEPTH] = '{default: '0}
) (
  input  logic          clk,
  input  logic [7:0]    addr,
  output logic [EW-1:0] data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // registered table lookup; indices past the table read as zero
  always_ff @(posedge clk) begin
    if (int'(addr) < DEPTH) data <= INIT[addr[IW-1:0]];
    else                    data <= '0;
  end

endmodule

// File: rtl/hwag_cfg_ctrl.sv
// hwag register-port sequencer: loads the config table after reset,
// then arbitrates the port to a host req/ack requester.
module hwag_cfg_ctrl
  import hwag_cfg_pkg::*;
#(
  parameter int TBL_LEN = 16,
  parameter int RD_LAT  = 1,
  parameter int AW      = 8,
  parameter int DW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic [7:0]      tbl_addr,
  input  logic [AW+DW:0]  tbl_data,
  output logic            ssram_we,
  output logic            ssram_re,
  output logic [AW-1:0]   ssram_addr,
  output logic [DW-1:0]   ssram_wdata,
  input  logic [DW-1:0]   ssram_rdata,
  input  logic            host_req,
  input  logic            host_we,
  input  logic [AW-1:0]   host_addr,
  input  logic [DW-1:0]   host_wdata,
  output logic            host_ack,
  output logic [DW-1:0]   host_rdata,
  input  logic            cfg_reload,
  output logic            cfg_done,
  output logic            cfg_err,
  output logic [AW-1:0]   err_addr
);

  localparam int         WCW      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [7:0] LAST_IDX = (TBL_LEN == 0) ? 8'd0 : 8'(TBL_LEN - 1);

  state_t          state_q, state_d;
  logic [7:0]      idx_q, idx_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic            op_verify_q, op_verify_d;
  logic [AW-1:0]   op_addr_q, op_addr_d;
  logic [DW-1:0]   op_data_q, op_data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [AW-1:0]   err_addr_q, err_addr_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            tbl_v;
  logic [AW-1:0]   tbl_a;
  logic [DW-1:0]   tbl_d;
  logic            wait_last;

  assign tbl_v     = tbl_data[AW+DW];
  assign tbl_a     = tbl_data[AW+DW-1:DW];
  assign tbl_d     = tbl_data[DW-1:0];
  assign wait_last = (wcnt_q == WCW'(RD_LAT - 1));

  assign tbl_addr  = idx_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign err_addr  = err_addr_q;

  // next-state, bus strobes and host handshake
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    op_verify_d = op_verify_q;
    op_addr_d   = op_addr_q;
    op_data_d   = op_data_q;
    done_d      = done_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    rdata_d     = rdata_q;
    ssram_we    = 1'b0;
    ssram_re    = 1'b0;
    ssram_addr  = '0;
    ssram_wdata = '0;
    host_ack    = 1'b0;
    host_rdata  = rdata_q;
    case (state_q)
      L_FETCH: begin
        if (TBL_LEN == 0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = L_WRITE;
        end
      end
      L_WRITE: begin
        ssram_we    = 1'b1;
        ssram_addr  = tbl_a;
        ssram_wdata = tbl_d;
        op_verify_d = tbl_v;
        op_addr_d   = tbl_a;
        op_data_d   = tbl_d;
        state_d     = L_READ;
      end
      L_READ: begin
        ssram_re   = 1'b1;
        ssram_addr = op_addr_q;
        wcnt_d     = '0;
        state_d    = L_WAIT;
      end
      L_WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wait_last) begin
          if (op_verify_q && (ssram_rdata != op_data_q)) begin
            err_d = 1'b1;
            if (!err_q) err_addr_d = op_addr_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = L_FETCH;
          end
        end
      end
      IDLE: begin
        if (cfg_reload) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_addr_d = '0;
          idx_d      = '0;
          state_d    = L_FETCH;
        end else if (host_req) begin
          op_addr_d = host_addr;
          op_data_d = host_wdata;
          state_d   = host_we ? H_WRITE : H_READ;
        end
      end
      H_WRITE: begin
        ssram_we    = 1'b1;
        ssram_addr  = op_addr_q;
        ssram_wdata = op_data_q;
        host_ack    = 1'b1;
        state_d     = IDLE;
      end
      H_READ: begin
        ssram_re   = 1'b1;
        ssram_addr = op_addr_q;
        wcnt_d     = '0;
        state_d    = H_WAIT;
      end
      H_WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wait_last) begin
          // read data is forwarded in the ack cycle and held afterwards
          host_ack   = 1'b1;
          host_rdata = ssram_rdata;
          rdata_d    = ssram_rdata;
          state_d    = IDLE;
        end
      end
      default: state_d = L_FETCH;
    endcase
  end

  // state and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= L_FETCH;
      idx_q       <= '0;
      wcnt_q      <= '0;
      op_verify_q <= 1'b0;
      op_addr_q   <= '0;
      op_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      op_verify_q <= op_verify_d;
      op_addr_q   <= op_addr_d;
      op_data_q   <= op_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_hwag_cfg_ctrl.sv
// Directed bench for hwag_cfg_ctrl: A = RD_LAT 1 with bench-side table,
// B = RD_LAT 2 fed by hwag_cfg_rom, C = empty table.
module tb_hwag_cfg_ctrl;
  import hwag_cfg_pkg::*;

  localparam int EW = 1 + CFG_AW + CFG_DW;
  localparam logic [EW-1:0] ROM_B [3] = '{{1'b1, 8'h00, 16'h0080},
                                          {1'b1, 8'h04, 16'h0039},
                                          {1'b1, 8'h3F, 16'h0007}};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- DUT A ----------------
  logic [7:0]    tbl_addr_a;
  logic [EW-1:0] tbl_data_a;
  logic          we_a, re_a;
  logic [7:0]    addr_a;
  logic [15:0]   wdata_a, rdata_a;
  logic          host_req_a, host_we_a, host_ack_a;
  logic [7:0]    host_addr_a;
  logic [15:0]   host_wdata_a, host_rdata_a;
  logic          cfg_reload_a, cfg_done_a, cfg_err_a;
  logic [7:0]    err_addr_a;

  hwag_cfg_ctrl #(.TBL_LEN(3), .RD_LAT(1), .AW(8), .DW(16)) dut_a (
    .clk(clk), .rst(rst), .tbl_addr(tbl_addr_a), .tbl_data(tbl_data_a),
    .ssram_we(we_a), .ssram_re(re_a), .ssram_addr(addr_a),
    .ssram_wdata(wdata_a), .ssram_rdata(rdata_a),
    .host_req(host_req_a), .host_we(host_we_a), .host_addr(host_addr_a),
    .host_wdata(host_wdata_a), .host_ack(host_ack_a), .host_rdata(host_rdata_a),
    .cfg_reload(cfg_reload_a), .cfg_done(cfg_done_a), .cfg_err(cfg_err_a),
    .err_addr(err_addr_a));

  logic [EW-1:0] tbl_a [3];
  logic [15:0]   mem_a [256];
  logic [255:0]  bad_map_a;
  logic [15:0]   rd1_a;

  always @(posedge clk) begin
    tbl_data_a <= (tbl_addr_a < 8'd3) ? tbl_a[tbl_addr_a[1:0]] : '0;
    if (we_a) mem_a[addr_a] <= wdata_a;
    if (re_a) rd1_a <= bad_map_a[addr_a] ? 16'h0006 : mem_a[addr_a];
  end
  assign rdata_a = rd1_a;

  // ---------------- DUT B ----------------
  logic [7:0]    tbl_addr_b;
  logic [EW-1:0] tbl_data_b;
  logic          we_b, re_b;
  logic [7:0]    addr_b;
  logic [15:0]   wdata_b, rdata_b;
  logic          host_req_b, host_we_b, host_ack_b;
  logic [7:0]    host_addr_b;
  logic [15:0]   host_wdata_b, host_rdata_b;
  logic          cfg_reload_b, cfg_done_b, cfg_err_b;
  logic [7:0]    err_addr_b;

  hwag_cfg_rom #(.DEPTH(3), .EW(EW), .INIT(ROM_B)) rom_b (
    .clk(clk), .addr(tbl_addr_b), .data(tbl_data_b));

  hwag_cfg_ctrl #(.TBL_LEN(3), .RD_LAT(2), .AW(8), .DW(16)) dut_b (
    .clk(clk), .rst(rst), .tbl_addr(tbl_addr_b), .tbl_data(tbl_data_b),
    .ssram_we(we_b), .ssram_re(re_b), .ssram_addr(addr_b),
    .ssram_wdata(wdata_b), .ssram_rdata(rdata_b),
    .host_req(host_req_b), .host_we(host_we_b), .host_addr(host_addr_b),
    .host_wdata(host_wdata_b), .host_ack(host_ack_b), .host_rdata(host_rdata_b),
    .cfg_reload(cfg_reload_b), .cfg_done(cfg_done_b), .cfg_err(cfg_err_b),
    .err_addr(err_addr_b));

  logic [15:0] mem_b [256];
  logic [15:0] rd1_b, rd2_b;

  always @(posedge clk) begin
    if (we_b) mem_b[addr_b] <= wdata_b;
    if (re_b) rd1_b <= mem_b[addr_b];
    rd2_b <= rd1_b;
  end
  assign rdata_b = rd2_b;

  // ---------------- DUT C (empty table) ----------------
  logic [7:0]    tbl_addr_c;
  logic [EW-1:0] tbl_data_c = '0;
  logic          we_c, re_c, host_ack_c, cfg_done_c, cfg_err_c;
  logic [7:0]    addr_c, err_addr_c;
  logic [15:0]   wdata_c, host_rdata_c;
  logic [15:0]   rdata_c = '0;
  logic          zero_c = 1'b0;
  logic [7:0]    zaddr_c = '0;
  logic [15:0]   zdata_c = '0;

  hwag_cfg_ctrl #(.TBL_LEN(0), .RD_LAT(1), .AW(8), .DW(16)) dut_c (
    .clk(clk), .rst(rst), .tbl_addr(tbl_addr_c), .tbl_data(tbl_data_c),
    .ssram_we(we_c), .ssram_re(re_c), .ssram_addr(addr_c),
    .ssram_wdata(wdata_c), .ssram_rdata(rdata_c),
    .host_req(zero_c), .host_we(zero_c), .host_addr(zaddr_c),
    .host_wdata(zdata_c), .host_ack(host_ack_c), .host_rdata(host_rdata_c),
    .cfg_reload(zero_c), .cfg_done(cfg_done_c), .cfg_err(cfg_err_c),
    .err_addr(err_addr_c));

  // ---------------- expectations / logs ----------------
  logic [7:0]  exp_addr [3] = '{8'h00, 8'h04, 8'h3F};
  logic [15:0] exp_data [3] = '{16'h0080, 16'h0039, 16'h0007};
  logic [7:0]  wl_addr [8];
  logic [15:0] wl_data [8];
  int          wl_cyc [8];
  int          nw;

  task automatic clear_log();
    nw = 0;
    for (int i = 0; i < 8; i++) begin
      wl_addr[i] = 'x;
      wl_data[i] = 'x;
      wl_cyc[i]  = -1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    host_req_a = 0; host_we_a = 0; host_addr_a = '0; host_wdata_a = '0; cfg_reload_a = 0;
    host_req_b = 0; host_we_b = 0; host_addr_b = '0; host_wdata_b = '0; cfg_reload_b = 0;
    repeat (2) @(negedge clk);
  endtask

  // run a load on A from release, logging writes and the cfg_done rise
  task automatic run_load_a(input int ncyc, output int done_cyc, output int viol);
    clear_log();
    done_cyc = -1;
    viol = 0;
    rst = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (we_a && nw < 8) begin
        wl_addr[nw] = addr_a; wl_data[nw] = wdata_a; wl_cyc[nw] = c; nw++;
      end
      if (we_a && re_a) viol++;
      if (!we_a && !re_a && (addr_a !== '0 || wdata_a !== '0)) viol++;
      if (cfg_done_a && done_cyc < 0) done_cyc = c;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({tbl_addr_a, we_a, re_a, addr_a, wdata_a, host_ack_a, host_rdata_a,
         cfg_done_a, cfg_err_a, err_addr_a} !== '0) begin
      n_bad++; $display("FAIL reset_a: outputs not all zero (we=%b re=%b addr=%h done=%b)",
                        we_a, re_a, addr_a, cfg_done_a);
    end
    n_cmp++;
    if ({tbl_addr_b, we_b, re_b, addr_b, wdata_b, host_ack_b, host_rdata_b,
         cfg_done_b, cfg_err_b, err_addr_b} !== '0) begin
      n_bad++; $display("FAIL reset_b: outputs not all zero");
    end
    rst = 1'b1;
    n_cmp++;
    if (cfg_done_c !== 1'b0) begin
      n_bad++; $display("FAIL empty_done_c0: got %b want 0", cfg_done_c);
    end
    @(negedge clk);
    n_cmp++;
    if (cfg_done_c !== 1'b1 || cfg_done_a !== 1'b0) begin
      n_bad++; $display("FAIL empty_done_c1: c=%b want 1, a=%b want 0", cfg_done_c, cfg_done_a);
    end
  endtask

  task automatic test_load();
    int done_cyc, viol;
    bad_map_a = '0;
    do_reset();
    run_load_a(16, done_cyc, viol);
    n_cmp++;
    if (nw !== 3) begin n_bad++; $display("FAIL load_nwrites: got %0d want 3", nw); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wl_addr[i] !== exp_addr[i] || wl_data[i] !== exp_data[i] || wl_cyc[i] != 1 + 4 * i) begin
        n_bad++;
        $display("FAIL load_write%0d: got %h:%h @%0d want %h:%h @%0d", i, wl_addr[i], wl_data[i],
                 wl_cyc[i], exp_addr[i], exp_data[i], 1 + 4 * i);
      end
    end
    n_cmp++;
    if (done_cyc != 12) begin n_bad++; $display("FAIL load_done_cycle: got %0d want 12", done_cyc); end
    n_cmp++;
    if (cfg_err_a !== 1'b0) begin n_bad++; $display("FAIL load_err: got %b want 0", cfg_err_a); end
    n_cmp++;
    if (viol != 0) begin n_bad++; $display("FAIL load_bus_rules: got %0d violations want 0", viol); end
  endtask

  task automatic test_verify_mismatch();
    int done_cyc, viol;
    bad_map_a = '0;
    bad_map_a[8'h3F] = 1'b1;
    do_reset();
    run_load_a(16, done_cyc, viol);
    n_cmp++;
    if (nw !== 3 || cfg_done_a !== 1'b1) begin
      n_bad++; $display("FAIL mis_complete: writes %0d done %b want 3 1", nw, cfg_done_a);
    end
    n_cmp++;
    if (cfg_err_a !== 1'b1 || err_addr_a !== 8'h3F) begin
      n_bad++; $display("FAIL mis_err: got %b/%h want 1/3f", cfg_err_a, err_addr_a);
    end
    // two mismatches: first address must stick
    bad_map_a[8'h04] = 1'b1;
    do_reset();
    run_load_a(16, done_cyc, viol);
    n_cmp++;
    if (cfg_err_a !== 1'b1 || err_addr_a !== 8'h04) begin
      n_bad++; $display("FAIL mis_first_addr: got %b/%h want 1/04", cfg_err_a, err_addr_a);
    end
    // reload in IDLE clears the error state and reloads cleanly
    bad_map_a = '0;
    cfg_reload_a = 1'b1;
    @(negedge clk);
    cfg_reload_a = 1'b0;
    n_cmp++;
    if ({cfg_done_a, cfg_err_a, err_addr_a} !== '0) begin
      n_bad++; $display("FAIL mis_reload_clear: done %b err %b addr %h want 0 0 00",
                        cfg_done_a, cfg_err_a, err_addr_a);
    end
    repeat (12) @(negedge clk);
    n_cmp++;
    if (cfg_done_a !== 1'b1 || cfg_err_a !== 1'b0) begin
      n_bad++; $display("FAIL mis_reload_done: done %b err %b want 1 0", cfg_done_a, cfg_err_a);
    end
  endtask

  task automatic test_unverified();
    int done_cyc, viol;
    tbl_a[2] = mk_entry(1'b0, HWACR0, 16'h0007);
    bad_map_a = '0;
    bad_map_a[8'h3F] = 1'b1;
    do_reset();
    run_load_a(16, done_cyc, viol);
    n_cmp++;
    if (cfg_err_a !== 1'b0 || cfg_done_a !== 1'b1) begin
      n_bad++; $display("FAIL unverified: err %b done %b want 0 1", cfg_err_a, cfg_done_a);
    end
    tbl_a[2] = mk_entry(1'b1, HWACR0, 16'h0007);
    bad_map_a = '0;
  endtask

  task automatic test_host_write();
    int done_cyc, ack_cyc, n_ack;
    logic ack_we;
    logic [7:0] ack_addr;
    logic [15:0] ack_wd;
    done_cyc = -1; ack_cyc = -1; n_ack = 0; ack_we = 0; ack_addr = '0; ack_wd = '0;
    do_reset();
    rst = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (cfg_done_a && done_cyc < 0) done_cyc = c;
      if (host_ack_a) begin
        n_ack++;
        if (ack_cyc < 0) begin ack_cyc = c; ack_we = we_a; ack_addr = addr_a; ack_wd = wdata_a; end
        host_req_a = 1'b0;
      end
      if (c == 2) begin host_req_a = 1'b1; host_we_a = 1'b1; host_addr_a = HWATHVL; host_wdata_a = 16'h0002; end
      cfg_reload_a = (c == 5);  // reload during load must be ignored
    end
    n_cmp++;
    if (done_cyc != 12) begin n_bad++; $display("FAIL hw_done_cycle: got %0d want 12", done_cyc); end
    n_cmp++;
    if (ack_cyc != 13 || n_ack != 1) begin
      n_bad++; $display("FAIL hw_ack: cycle %0d count %0d want 13 1", ack_cyc, n_ack);
    end
    n_cmp++;
    if (ack_we !== 1'b1 || ack_addr !== 8'h46 || ack_wd !== 16'h0002) begin
      n_bad++; $display("FAIL hw_bus: we %b addr %h data %h want 1 46 0002", ack_we, ack_addr, ack_wd);
    end
    n_cmp++;
    if (mem_a[8'h46] !== 16'h0002) begin
      n_bad++; $display("FAIL hw_mem: got %h want 0002", mem_a[8'h46]);
    end
  endtask

  task automatic test_host_read();
    int done_cyc, wack, re_off, ack_off, n_ack;
    logic [7:0]  re_addr;
    logic [15:0] rd, held;
    done_cyc = -1; wack = -1; re_off = -1; ack_off = -1; n_ack = 0;
    re_addr = 'x; rd = 'x; held = 'x;
    do_reset();
    rst = 1'b1;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (cfg_done_b) done_cyc = c;
    end
    n_cmp++;
    if (done_cyc != 15) begin n_bad++; $display("FAIL hr_done_cycle: got %0d want 15", done_cyc); end
    n_cmp++;
    if (host_rdata_b !== 16'h0000) begin
      n_bad++; $display("FAIL hr_rdata_reset: got %h want 0000", host_rdata_b);
    end
    host_req_b = 1'b1; host_we_b = 1'b1; host_addr_b = HWATHVL; host_wdata_b = 16'h0002;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (host_ack_b && wack < 0) begin wack = k; host_req_b = 1'b0; end
    end
    n_cmp++;
    if (wack != 1) begin n_bad++; $display("FAIL hr_write_ack: got %0d want 1", wack); end
    host_req_b = 1'b1; host_we_b = 1'b0; host_addr_b = HWATHVL; host_wdata_b = 16'hFFFF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ack_off > 0 && k == ack_off + 1) held = host_rdata_b;
      if (re_b && re_off < 0) begin re_off = k; re_addr = addr_b; end
      if (host_ack_b) begin
        n_ack++;
        if (ack_off < 0) begin ack_off = k; rd = host_rdata_b; end
        host_req_b = 1'b0;
      end
    end
    n_cmp++;
    if (re_off != 1 || re_addr !== 8'h46) begin
      n_bad++; $display("FAIL hr_re: offset %0d addr %h want 1 46", re_off, re_addr);
    end
    n_cmp++;
    if (ack_off != 3 || n_ack != 1) begin
      n_bad++; $display("FAIL hr_ack: offset %0d count %0d want 3 1", ack_off, n_ack);
    end
    n_cmp++;
    if (rd !== 16'h0002) begin n_bad++; $display("FAIL hr_rdata: got %h want 0002", rd); end
    n_cmp++;
    if (held !== 16'h0002) begin n_bad++; $display("FAIL hr_rdata_hold: got %h want 0002", held); end
  endtask

  task automatic test_reload_vs_host();
    logic d1;
    int done_off, ack_off, nlw;
    logic [7:0]  first_addr;
    d1 = 1'bx; done_off = -1; ack_off = -1; nlw = 0; first_addr = 'x;
    cfg_reload_b = 1'b1;
    host_req_b = 1'b1; host_we_b = 1'b1; host_addr_b = HWATHVL; host_wdata_b = 16'h1234;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) begin d1 = cfg_done_b; cfg_reload_b = 1'b0; end
      if (we_b && !host_ack_b) begin
        if (nlw == 0) first_addr = addr_b;
        nlw++;
      end
      if (host_ack_b && ack_off < 0) begin ack_off = k; host_req_b = 1'b0; end
      if (cfg_done_b && done_off < 0) done_off = k;
    end
    n_cmp++;
    if (d1 !== 1'b0) begin n_bad++; $display("FAIL rl_done_drop: got %b want 0", d1); end
    n_cmp++;
    if (done_off != 16) begin n_bad++; $display("FAIL rl_done_rise: got %0d want 16", done_off); end
    n_cmp++;
    if (ack_off != 17) begin n_bad++; $display("FAIL rl_host_ack: got %0d want 17", ack_off); end
    n_cmp++;
    if (nlw != 3 || first_addr !== 8'h00) begin
      n_bad++; $display("FAIL rl_writes: count %0d first %h want 3 00", nlw, first_addr);
    end
    n_cmp++;
    if (mem_b[8'h46] !== 16'h1234) begin
      n_bad++; $display("FAIL rl_mem: got %h want 1234", mem_b[8'h46]);
    end
  endtask

  task automatic test_reset_mid();
    int done_cyc, viol;
    do_reset();
    rst = 1'b1;
    repeat (9) @(negedge clk);
    n_cmp++;
    if (we_a !== 1'b1 || addr_a !== 8'h3F || wdata_a !== 16'h0007) begin
      n_bad++; $display("FAIL rm_entry2_write: we %b addr %h data %h want 1 3f 0007", we_a, addr_a, wdata_a);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({tbl_addr_a, we_a, re_a, addr_a, wdata_a, host_ack_a, host_rdata_a,
         cfg_done_a, cfg_err_a, err_addr_a} !== '0) begin
      n_bad++; $display("FAIL rm_outputs_zero: we %b re %b addr %h tbl %h", we_a, re_a, addr_a, tbl_addr_a);
    end
    run_load_a(14, done_cyc, viol);
    n_cmp++;
    if (wl_cyc[0] != 1 || wl_addr[0] !== 8'h00) begin
      n_bad++; $display("FAIL rm_restart: first write @%0d addr %h want @1 00", wl_cyc[0], wl_addr[0]);
    end
    n_cmp++;
    if (done_cyc != 12 || nw != 3) begin
      n_bad++; $display("FAIL rm_reload: done @%0d writes %0d want 12 3", done_cyc, nw);
    end
  endtask

  initial begin
    rst = 1'b0;
    bad_map_a = '0;
    tbl_a[0] = mk_entry(1'b1, 8'h00, 16'h0080);
    tbl_a[1] = mk_entry(1'b1, HWATHNB, 16'h0039);
    tbl_a[2] = mk_entry(1'b1, HWACR0, 16'h0007);
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    test_reset();
    test_load();
    test_verify_mismatch();
    test_unverified();
    test_host_write();
    test_host_read();
    test_reload_vs_host();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
